// File: rtl/time_split_ctrl.sv
// Drives the shared divider to split an elapsed centisecond count into min/sec/centis.
// Two back-to-back divides (T/100, then seconds/60); remainders are formed locally.
module time_split_ctrl #(
  parameter int DIV_CS  = 100,
  parameter int DIV_S   = 60,
  parameter int TIMEOUT = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] time_cs,
  output logic        busy,
  output logic        valid,
  output logic        err,
  output logic [3:0]  minutes,
  output logic [5:0]  seconds,
  output logic [6:0]  centis,
  output logic        div_init,
  output logic [15:0] div_op_a,
  output logic [15:0] div_op_b,
  input  logic        div_done,
  input  logic [31:0] div_result
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REL1, S_REQ1, S_WAIT1, S_REL2, S_REQ2, S_WAIT2, S_FIN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   t_q, t_d;
  logic [15:0]   q1_q, q1_d;
  logic [6:0]    cen_tmp_q, cen_tmp_d;
  logic [3:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [6:0]    cen_q, cen_d;
  logic          err_q, err_d;
  logic [15:0]   op_a_q, op_a_d;
  logic [15:0]   op_b_q, op_b_d;

  logic [15:0] quot;
  logic [15:0] cs_rem;
  logic [15:0] s_rem;
  logic        tmo;
  logic        unused_result_hi;

  assign quot             = div_result[15:0];
  assign unused_result_hi = ^div_result[31:16];
  // Q*divisor never exceeds the dividend, so 16-bit products cannot overflow.
  assign cs_rem = t_q - quot * 16'(DIV_CS);
  assign s_rem  = q1_q - quot * 16'(DIV_S);
  assign tmo    = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    t_d       = t_q;
    q1_d      = q1_q;
    cen_tmp_d = cen_tmp_q;
    min_d     = min_q;
    sec_d     = sec_q;
    cen_d     = cen_q;
    err_d     = err_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          t_d     = time_cs;
          err_d   = 1'b0;
          state_d = S_REL1;
        end
      end
      // The divider ignores init while done is still high from its last run.
      S_REL1, S_REL2: begin
        if (!div_done) begin
          state_d = (state_q == S_REL1) ? S_REQ1 : S_REQ2;
          op_a_d  = (state_q == S_REL1) ? t_q : q1_q;
          op_b_d  = (state_q == S_REL1) ? 16'(DIV_CS) : 16'(DIV_S);
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REQ1:  state_d = S_WAIT1;
      S_REQ2:  state_d = S_WAIT2;
      S_WAIT1, S_WAIT2: begin
        if (div_done) begin
          if (state_q == S_WAIT1) begin
            q1_d      = quot;
            cen_tmp_d = cs_rem[6:0];
            state_d   = S_REL2;
          end else begin
            min_d   = quot[3:0];
            sec_d   = s_rem[5:0];
            cen_d   = cen_tmp_q;
            state_d = S_FIN;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      t_q       <= '0;
      q1_q      <= '0;
      cen_tmp_q <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      cen_q     <= '0;
      err_q     <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      t_q       <= t_d;
      q1_q      <= q1_d;
      cen_tmp_q <= cen_tmp_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      cen_q     <= cen_d;
      err_q     <= err_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
    end
  end

  assign busy     = (state_q != S_IDLE) && (state_q != S_FIN);
  assign valid    = (state_q == S_FIN);
  assign div_init = (state_q == S_REQ1) || (state_q == S_REQ2);
  assign err      = err_q;
  assign minutes  = min_q;
  assign seconds  = sec_q;
  assign centis   = cen_q;
  assign div_op_a = op_a_q;
  assign div_op_b = op_b_q;

endmodule

// File: tb/tb_time_split_ctrl.sv
// Bench for time_split_ctrl: behavioural divider model plus a reference model
// computing minutes/seconds/centis directly from the elapsed time.
module tb_time_split_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] time_cs;
  logic        busy, valid, err;
  logic [3:0]  minutes;
  logic [5:0]  seconds;
  logic [6:0]  centis;
  logic        div_init;
  logic [15:0] div_op_a, div_op_b;
  logic        div_done;
  logic [31:0] div_result;

  time_split_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .time_cs(time_cs),
    .busy(busy), .valid(valid), .err(err),
    .minutes(minutes), .seconds(seconds), .centis(centis),
    .div_init(div_init), .div_op_a(div_op_a), .div_op_b(div_op_b),
    .div_done(div_done), .div_result(div_result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Expected results {minutes, seconds, centis}
  logic [16:0] exp_q[$];
  logic [16:0] last_exp = '0;
  logic [15:0] opb_q[$];
  int          init_count = 0;
  bit          hang = 1'b0;

  function automatic logic [16:0] ref_split(input int t);
    int m, s, c;
    m = t / 6000;
    s = (t / 100) % 60;
    c = t % 100;
    return {4'(m), 6'(s), 7'(c)};
  endfunction

  // Divider model: random latency, done held ~30 cycles, result cleared on release.
  logic [15:0] lat_a, lat_b;
  int          lat_cnt, hold_cnt;
  bit          div_busy;
  initial begin
    div_done = 1'b0; div_result = '0; div_busy = 1'b0; hold_cnt = 0; lat_cnt = 0;
    lat_a = '0; lat_b = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        div_done = 1'b0; div_result = '0; div_busy = 1'b0; hold_cnt = 0;
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) begin div_done = 1'b0; div_result = '0; end
      end else if (div_busy) begin
        if (lat_cnt > 0) lat_cnt--;
        else begin
          div_busy   = 1'b0;
          div_done   = 1'b1;
          div_result = {16'hdead, lat_a / lat_b};
          hold_cnt   = $urandom_range(25, 35);
          check("op_a_stable", div_op_a, lat_a);
          check("op_b_stable", div_op_b, lat_b);
        end
      end else if (div_init && !div_done && !hang) begin
        lat_a = div_op_a; lat_b = div_op_b;
        init_count++;
        opb_q.push_back(div_op_b);
        lat_cnt  = $urandom_range(10, 50);
        div_busy = 1'b1;
      end
    end
  end

  task automatic do_convert(input logic [15:0] t, input bit spam);
    logic [16:0] e;
    int   base_init, base_opb, extra;
    bit   got;
    base_init = init_count;
    base_opb  = opb_q.size();
    exp_q.push_back(ref_split(int'(t)));
    @(negedge clk);
    time_cs = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_cleared", err, 0);
    got = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (spam && i == 3) begin time_cs = 16'd1; start = 1'b1; end
      if (spam && i == 12) start = 1'b0;
      if (valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    start = 1'b0;
    check("valid_seen", got, 1);
    if (got) begin
      e = exp_q.pop_front();
      last_exp = e;
      check("busy_drops_with_valid", busy, 0);
      check("minutes", minutes, e[16:13]);
      check("seconds", seconds, e[12:7]);
      check("centis", centis, e[6:0]);
      check("init_pulses", init_count - base_init, 2);
      if (opb_q.size() >= base_opb + 2) begin
        check("op_b_first", opb_q[base_opb], 100);
        check("op_b_second", opb_q[base_opb + 1], 60);
      end else check("op_b_log_size", opb_q.size() - base_opb, 2);
      extra = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (valid) extra++;
      end
      check("single_valid", extra, 0);
      check("results_hold", {minutes, seconds, centis}, e);
    end else void'(exp_q.pop_front());
  endtask

  task automatic do_timeout();
    int cyc, vcount, base_init;
    hang = 1'b1;
    base_init = init_count;
    @(negedge clk);
    time_cs = 16'd4321; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; vcount = 0;
    while (!err && cyc < 400) begin
      if (valid) vcount++;
      @(negedge clk);
      cyc++;
    end
    check("timeout_err", err, 1);
    check("timeout_window", (cyc >= 125 && cyc <= 135), 1);
    check("timeout_no_valid", vcount, 0);
    check("timeout_not_busy", busy, 0);
    check("timeout_outputs_hold", {minutes, seconds, centis}, last_exp);
    check("timeout_no_init_taken", init_count - base_init, 0);
    repeat (5) @(negedge clk);
    check("err_sticky", err, 1);
    hang = 1'b0;
  endtask

  task automatic do_reset_mid();
    int base_init, n;
    base_init = init_count;
    @(negedge clk);
    time_cs = 16'd30000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (init_count < base_init + 2 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("reached_wait2", init_count - base_init, 2);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_err", err, 0);
    check("rst_results", {minutes, seconds, centis}, 0);
    check("rst_div_if", {div_init, div_op_a, div_op_b}, 0);
    @(negedge clk);
    reset = 1'b0;
    last_exp = '0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; time_cs = '0;
    #12;
    check("reset_outputs", {busy, valid, err, minutes, seconds, centis}, 0);
    check("reset_div_if", {div_init, div_op_a, div_op_b}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    do_convert(16'd0, 1'b0);
    do_convert(16'd12345, 1'b0);
    do_convert(16'd65535, 1'b0);
    do_convert(16'd5999, 1'b0);
    do_convert(16'd6000, 1'b0);
    do_convert(16'd7777, 1'b1);
    do_timeout();
    do_convert(16'd12345, 1'b0);
    do_reset_mid();
    do_convert(16'd5999, 1'b0);
    for (int k = 0; k < 20; k++)
      do_convert(16'($urandom_range(0, 65535)), k[2]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
